pipe_irq_ctrl: RTL and testbench
================================

Name: pipe_irq_ctrl

Overview:
Pipeline control and interrupt sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the shared stall vector.
- Sequences machine-interrupt entry and mret exit.
- On entry: flushes the mem_wb register, writes mepc/mcause/mstatus through a dedicated CSR write port, then redirects the PC.
- Sits beside the pipeline registers and drives their stall and flush_interrupt inputs.

Parameters:
ADDR_W, 32, PC/CSR data width
CSR_AW, 12, CSR address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-low reset
stallreq_id_i  in  1  id-stage stall request (load-use)
stallreq_ex_i  in  1  ex-stage stall request (multicycle op)
stallreq_mem_i  in  1  mem-stage stall request (bus wait)
irq_ext_i  in  1  level external interrupt
mstatus_i  in  ADDR_W  current mstatus
mie_i  in  ADDR_W  current mie
mtvec_i  in  ADDR_W  trap vector (direct mode, bits[1:0] ignored)
mepc_i  in  ADDR_W  current mepc
ex_pc_i  in  ADDR_W  pc of instruction in ex
ex_valid_i  in  1  ex holds a real instruction
mret_i  in  1  ex holds mret
stall_o  out  6  {wb,mem,ex,id,if,pc}
flush_interrupt_o  out  1  flush pipeline registers
redirect_o  out  1  load redirect_pc_o into pc
redirect_pc_o  out  ADDR_W  target pc
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  CSR_AW  CSR address
csr_wdata_o  out  ADDR_W  CSR data
irq_ack_o  out  1  one-cycle pulse at trap entry

Behaviour:
- Reset (rst_i==0 at posedge):
  - state=IDLE.
  - All registered outputs 0: stall_o=6'b0, flush_interrupt_o=0, redirect_o=0, redirect_pc_o=0, csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, irq_ack_o=0.
  - Captured epc/cause registers cleared.
  - Reset mid-sequence aborts with no further CSR writes.
- All outputs are registered; every decision takes effect 1 cycle after its inputs are sampled.
- Stall merge in IDLE, highest priority wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - none: 0
- Pending interrupt: mstatus_i[3] (MIE) & mie_i[11] (MEIE) & irq_ext_i.
- FSM states: IDLE, DRAIN, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, JUMP, MRET_RST.
  - IDLE:
    - pending & ex_valid_i → latch epc=ex_pc_i; go to DRAIN. Interrupt beats mret in the same cycle.
    - else mret_i → MRET_RST.
    - pending with ex_valid_i=0 → wait in IDLE.
  - DRAIN:
    - stall_o=6'b001111 (freeze pc..ex, let mem/wb retire).
    - Stay while stallreq_mem_i=1; leave when it drops → SAVE_EPC.
  - SAVE_EPC:
    - stall_o=6'b001111; flush_interrupt_o=1.
    - csr write 0x341 ← epc.
  - SAVE_CAUSE: csr write 0x342 ← 32'h8000000B.
  - SAVE_STATUS:
    - csr write 0x300 ← mstatus_i with MPIE(bit7)=MIE, MIE=0, MPP(bits12:11)=2'b11.
    - irq_ack_o=1.
  - JUMP (lasts 1 cycle) → IDLE:
    - redirect_o=1, redirect_pc_o={mtvec_i[31:2],2'b00}.
    - flush_interrupt_o=1; stall_o=0.
  - MRET_RST:
    - stall_o=6'b001111.
    - csr write 0x300 ← mstatus_i with MIE=MPIE, MPIE=1.
    - Then JUMP with redirect_pc_o=mepc_i (flush asserted).
- SAVE_* states each last exactly 1 cycle with stall_o=6'b001111. csr_we_o is high only in SAVE_*/MRET_RST.
- stallreq_* inputs are ignored outside IDLE/DRAIN.
- An interrupt is never re-taken until the FSM has returned to IDLE.

Optional Feature:
PIPE_IRQ_TIMER_EN
- Defined:
  - Adds port irq_timer_i (1 bit).
  - Pending also when mstatus_i[3] & mie_i[7] & irq_timer_i.
  - External has priority: cause 0x8000000B if external pending, else 0x80000007.
  - Cause is latched on IDLE→DRAIN.
- Undefined: no port; cause is always 0x8000000B.

Decomposition:
- Shared defines file gets:
  - CSR addresses MSTATUS 12'h300, MIE 12'h304, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342
  - STALL_ID/EX/MEM vector constants
  - cause codes
  - FSM state encodings (3-bit)
- One sub-module: stall_merge (combinational priority encoder of stall requests).

Test Plan:
- stallreq_ex_i=1 and stallreq_id_i=1, no irq → stall_o=6'b001111 next cycle; drop both → 0.
- MIE=1, MEIE=1, irq_ext_i=1, ex_pc_i=0x80, ex_valid_i=1, mtvec_i=0x1003 → required sequence:
  - flush_interrupt_o pulses.
  - csr writes mepc=0x80, mcause=0x8000000B, mstatus MIE=0/MPIE=1 on consecutive cycles.
  - irq_ack_o pulses.
  - redirect_pc_o=0x1000.
- Same irq with stallreq_mem_i=1 for 3 cycles → stays in DRAIN 3 cycles, no CSR write until mem releases.
- mret_i=1, mepc_i=0x84, mstatus MPIE=1 → mstatus write with MIE=1, then redirect_pc_o=0x84.
- irq_ext_i=1 with MIE=0 → no flush, no CSR write. Also rst_i=0 during SAVE_CAUSE → all outputs 0 next cycle, no mstatus write.

Source files
------------

// File: rtl/pipe_irq_ctrl_pkg.sv
// Shared constants, CSR addresses and FSM encoding for the pipeline/interrupt sequencer.
package pipe_irq_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // stall vector layout {wb,mem,ex,id,if,pc}
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP  = 11;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DRAIN       = 3'd1,
        ST_SAVE_EPC    = 3'd2,
        ST_SAVE_CAUSE  = 3'd3,
        ST_SAVE_STATUS = 3'd4,
        ST_JUMP        = 3'd5,
        ST_MRET_RST    = 3'd6
    } state_e;

endpackage

// File: rtl/pipe_irq_ctrl_stall_merge.sv
// Priority merge of per-stage stall requests into the shared stall vector.
module pipe_irq_ctrl_stall_merge
    import pipe_irq_ctrl_pkg::*;
(
    input  logic       req_id,
    input  logic       req_ex,
    input  logic       req_mem,
    output logic [5:0] stall_c
);

    always_comb begin
        stall_c = STALL_NONE;
        if (req_mem) begin
            stall_c = STALL_MEM;
        end else if (req_ex) begin
            stall_c = STALL_EX;
        end else if (req_id) begin
            stall_c = STALL_ID;
        end
    end

endmodule

// File: rtl/pipe_irq_ctrl.sv
// Pipeline stall merge plus machine-interrupt entry / mret exit sequencer.
// Optional timer interrupt source enabled by defining PIPE_IRQ_TIMER_EN.
module pipe_irq_ctrl
    import pipe_irq_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              stallreq_mem_i,
    input  logic              irq_ext_i,
`ifdef PIPE_IRQ_TIMER_EN
    input  logic              irq_timer_i,
`endif
    input  logic [ADDR_W-1:0] mstatus_i,
    input  logic [ADDR_W-1:0] mie_i,
    input  logic [ADDR_W-1:0] mtvec_i,
    input  logic [ADDR_W-1:0] mepc_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic              ex_valid_i,
    input  logic              mret_i,
    output logic [5:0]        stall_o,
    output logic              flush_interrupt_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [ADDR_W-1:0] csr_wdata_o,
    output logic              irq_ack_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] cause_q, cause_d;

    logic [5:0]        stall_d;
    logic              flush_d, redirect_d, csr_we_d, irq_ack_d;
    logic [ADDR_W-1:0] redirect_pc_d, csr_wdata_d;
    logic [CSR_AW-1:0] csr_waddr_d;

    logic [5:0]        merged_stall_c;
    logic              ext_pending_c, pending_c;
    logic [ADDR_W-1:0] cause_sel_c;
    logic [ADDR_W-1:0] trap_status_c, mret_status_c;
    logic              unused_bits;

    pipe_irq_ctrl_stall_merge u_stall_merge (
        .req_id  (stallreq_id_i),
        .req_ex  (stallreq_ex_i),
        .req_mem (stallreq_mem_i),
        .stall_c (merged_stall_c)
    );

    assign ext_pending_c = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MEIE] & irq_ext_i;

`ifdef PIPE_IRQ_TIMER_EN
    logic tmr_pending_c;
    assign tmr_pending_c = mstatus_i[MSTATUS_MIE] & mie_i[MIE_MTIE] & irq_timer_i;
    assign pending_c     = ext_pending_c | tmr_pending_c;
    assign cause_sel_c   = ext_pending_c ? ADDR_W'(CAUSE_EXT) : ADDR_W'(CAUSE_TIMER);
    assign unused_bits   = ^{mie_i, mtvec_i[1:0], CSR_MIE, CSR_MTVEC};
`else
    assign pending_c     = ext_pending_c;
    assign cause_sel_c   = ADDR_W'(CAUSE_EXT);
    assign unused_bits   = ^{mie_i, mtvec_i[1:0], CSR_MIE, CSR_MTVEC, CAUSE_TIMER, MIE_MTIE};
`endif

    // mstatus images written on trap entry and on mret
    always_comb begin
        trap_status_c                                = mstatus_i;
        trap_status_c[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
        trap_status_c[MSTATUS_MIE]                   = 1'b0;
        trap_status_c[MSTATUS_MPP+1:MSTATUS_MPP]     = 2'b11;
        mret_status_c                                = mstatus_i;
        mret_status_c[MSTATUS_MIE]                   = mstatus_i[MSTATUS_MPIE];
        mret_status_c[MSTATUS_MPIE]                  = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q           <= ST_IDLE;
            epc_q             <= '0;
            cause_q           <= '0;
            stall_o           <= '0;
            flush_interrupt_o <= 1'b0;
            redirect_o        <= 1'b0;
            redirect_pc_o     <= '0;
            csr_we_o          <= 1'b0;
            csr_waddr_o       <= '0;
            csr_wdata_o       <= '0;
            irq_ack_o         <= 1'b0;
        end else begin
            state_q           <= state_d;
            epc_q             <= epc_d;
            cause_q           <= cause_d;
            stall_o           <= stall_d;
            flush_interrupt_o <= flush_d;
            redirect_o        <= redirect_d;
            redirect_pc_o     <= redirect_pc_d;
            csr_we_o          <= csr_we_d;
            csr_waddr_o       <= csr_waddr_d;
            csr_wdata_o       <= csr_wdata_d;
            irq_ack_o         <= irq_ack_d;
        end
    end

    // Outputs are decoded for the state being entered, so they line up with it.
    always_comb begin
        state_d       = state_q;
        epc_d         = epc_q;
        cause_d       = cause_q;
        stall_d       = STALL_NONE;
        flush_d       = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = '0;
        csr_we_d      = 1'b0;
        csr_waddr_d   = '0;
        csr_wdata_d   = '0;
        irq_ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_c && ex_valid_i) begin
                    state_d = ST_DRAIN;
                    epc_d   = ex_pc_i;
                    cause_d = cause_sel_c;
                    stall_d = STALL_EX;
                end else if (mret_i) begin
                    state_d     = ST_MRET_RST;
                    stall_d     = STALL_EX;
                    csr_we_d    = 1'b1;
                    csr_waddr_d = CSR_AW'(CSR_MSTATUS);
                    csr_wdata_d = mret_status_c;
                end else begin
                    stall_d = merged_stall_c;
                end
            end
            ST_DRAIN: begin
                stall_d = STALL_EX;
                if (!stallreq_mem_i) begin
                    state_d     = ST_SAVE_EPC;
                    flush_d     = 1'b1;
                    csr_we_d    = 1'b1;
                    csr_waddr_d = CSR_AW'(CSR_MEPC);
                    csr_wdata_d = epc_q;
                end
            end
            ST_SAVE_EPC: begin
                state_d     = ST_SAVE_CAUSE;
                stall_d     = STALL_EX;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_AW'(CSR_MCAUSE);
                csr_wdata_d = cause_q;
            end
            ST_SAVE_CAUSE: begin
                state_d     = ST_SAVE_STATUS;
                stall_d     = STALL_EX;
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_AW'(CSR_MSTATUS);
                csr_wdata_d = trap_status_c;
                irq_ack_d   = 1'b1;
            end
            ST_SAVE_STATUS: begin
                state_d       = ST_JUMP;
                flush_d       = 1'b1;
                redirect_d    = 1'b1;
                redirect_pc_d = {mtvec_i[ADDR_W-1:2], 2'b00};
            end
            ST_MRET_RST: begin
                state_d       = ST_JUMP;
                flush_d       = 1'b1;
                redirect_d    = 1'b1;
                redirect_pc_d = mepc_i;
            end
            ST_JUMP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_irq_ctrl.sv
// Directed + randomized bench for pipe_irq_ctrl with a transaction-level reference model.
module tb_pipe_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        irq_ext_i;
`ifdef PIPE_IRQ_TIMER_EN
    logic        irq_timer_i;
`endif
    logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i, ex_pc_i;
    logic        ex_valid_i, mret_i;
    logic [5:0]  stall_o;
    logic        flush_interrupt_o, redirect_o, csr_we_o, irq_ack_o;
    logic [31:0] redirect_pc_o, csr_wdata_o;
    logic [11:0] csr_waddr_o;

    always #5 clk_i = ~clk_i;

    pipe_irq_ctrl dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .stallreq_id_i     (stallreq_id_i),
        .stallreq_ex_i     (stallreq_ex_i),
        .stallreq_mem_i    (stallreq_mem_i),
        .irq_ext_i         (irq_ext_i),
`ifdef PIPE_IRQ_TIMER_EN
        .irq_timer_i       (irq_timer_i),
`endif
        .mstatus_i         (mstatus_i),
        .mie_i             (mie_i),
        .mtvec_i           (mtvec_i),
        .mepc_i            (mepc_i),
        .ex_pc_i           (ex_pc_i),
        .ex_valid_i        (ex_valid_i),
        .mret_i            (mret_i),
        .stall_o           (stall_o),
        .flush_interrupt_o (flush_interrupt_o),
        .redirect_o        (redirect_o),
        .redirect_pc_o     (redirect_pc_o),
        .csr_we_o          (csr_we_o),
        .csr_waddr_o       (csr_waddr_o),
        .csr_wdata_o       (csr_wdata_o),
        .irq_ack_o         (irq_ack_o)
    );

    // Reference model: a trap or mret expands into a list of output beats.
    typedef enum int {B_EPC, B_CAUSE, B_STATUS, B_JTRAP, B_MRET, B_JMRET, B_GAP} beat_e;
    beat_e       beats[$];
    bit          draining;
    logic [31:0] m_epc, m_cause;

    logic [5:0]  e_stall;
    logic        e_flush, e_redir, e_we, e_ack;
    logic [31:0] e_pc, e_wdata;
    logic [11:0] e_waddr;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        e_we    = 1'b1;
        e_waddr = a;
        e_wdata = d;
    endtask

    task automatic apply_beat(input beat_e b);
        logic [31:0] ms;
        ms = mstatus_i;
        case (b)
            B_EPC:    begin e_stall = 6'b001111; e_flush = 1'b1; csr_write(12'h341, m_epc); end
            B_CAUSE:  begin e_stall = 6'b001111; csr_write(12'h342, m_cause); end
            B_STATUS: begin
                e_stall = 6'b001111;
                e_ack   = 1'b1;
                csr_write(12'h300, (ms & ~32'h0000_1888) | 32'h0000_1800 | (32'(ms[3]) << 7));
            end
            B_JTRAP:  begin e_redir = 1'b1; e_flush = 1'b1; e_pc = mtvec_i & ~32'h3; end
            B_MRET:   begin
                e_stall = 6'b001111;
                csr_write(12'h300, (ms & ~32'h0000_0088) | 32'h0000_0080 | (32'(ms[7]) << 3));
            end
            B_JMRET:  begin e_redir = 1'b1; e_flush = 1'b1; e_pc = mepc_i; end
            default:  ;
        endcase
    endtask

    task automatic model_step();
        logic ext, tmr;
        e_stall = '0; e_flush = 0; e_redir = 0; e_we = 0; e_ack = 0;
        e_pc = '0; e_wdata = '0; e_waddr = '0;
        if (!rst_i) begin
            beats.delete();
            draining = 0;
            m_epc    = '0;
            m_cause  = '0;
        end else if (draining) begin
            e_stall = 6'b001111;
            if (!stallreq_mem_i) begin
                draining = 0;
                apply_beat(B_EPC);
                beats.push_back(B_CAUSE);
                beats.push_back(B_STATUS);
                beats.push_back(B_JTRAP);
                beats.push_back(B_GAP);
            end
        end else if (beats.size() > 0) begin
            apply_beat(beats.pop_front());
        end else begin
            ext = mstatus_i[3] & mie_i[11] & irq_ext_i;
`ifdef PIPE_IRQ_TIMER_EN
            tmr = mstatus_i[3] & mie_i[7] & irq_timer_i;
`else
            tmr = 1'b0;
`endif
            if ((ext | tmr) && ex_valid_i) begin
                m_epc    = ex_pc_i;
                m_cause  = ext ? 32'h8000_000B : 32'h8000_0007;
                draining = 1;
                e_stall  = 6'b001111;
            end else if (mret_i) begin
                apply_beat(B_MRET);
                beats.push_back(B_JMRET);
                beats.push_back(B_GAP);
            end else begin
                e_stall = stallreq_mem_i ? 6'b011111 :
                          stallreq_ex_i  ? 6'b001111 :
                          stallreq_id_i  ? 6'b000111 : 6'b000000;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        chk("stall",       32'(stall_o),           32'(e_stall));
        chk("flush",       32'(flush_interrupt_o), 32'(e_flush));
        chk("redirect",    32'(redirect_o),        32'(e_redir));
        chk("redirect_pc", redirect_pc_o,          e_pc);
        chk("csr_we",      32'(csr_we_o),          32'(e_we));
        chk("csr_waddr",   32'(csr_waddr_o),       32'(e_waddr));
        chk("csr_wdata",   csr_wdata_o,            e_wdata);
        chk("irq_ack",     32'(irq_ack_o),         32'(e_ack));
    endtask

    task automatic quiet();
        stallreq_id_i = 0; stallreq_ex_i = 0; stallreq_mem_i = 0;
        irq_ext_i = 0; mret_i = 0; ex_valid_i = 1;
`ifdef PIPE_IRQ_TIMER_EN
        irq_timer_i = 0;
`endif
    endtask

    initial begin
        draining = 0;
        m_epc = '0; m_cause = '0;
        rst_i = 0;
        quiet();
        mstatus_i = 32'h0; mie_i = 32'h0; mtvec_i = 32'h1003; mepc_i = 32'h0; ex_pc_i = 32'h0;
        tick(); tick();
        rst_i = 1;
        tick();

        // stall merge: ex beats id, then release
        stallreq_ex_i = 1; stallreq_id_i = 1;
        tick();
        stallreq_ex_i = 0; stallreq_id_i = 0;
        tick();

        // external interrupt entry
        mstatus_i = 32'h8; mie_i = 32'h800; ex_pc_i = 32'h80; irq_ext_i = 1;
        tick();
        irq_ext_i = 0;
        repeat (6) tick();

        // same entry with mem stall held 3 cycles
        irq_ext_i = 1; stallreq_mem_i = 1;
        tick();
        irq_ext_i = 0;
        tick(); tick();
        stallreq_mem_i = 0;
        repeat (6) tick();

        // mret exit
        mstatus_i = 32'h80; mepc_i = 32'h84; mret_i = 1;
        tick();
        mret_i = 0;
        repeat (3) tick();

        // masked interrupt is ignored
        mstatus_i = 32'h0; irq_ext_i = 1;
        repeat (3) tick();

        // reset lands while in SAVE_CAUSE
        mstatus_i = 32'h8; irq_ext_i = 1;
        tick();
        irq_ext_i = 0;
        tick(); tick();
        rst_i = 0;
        tick();
        rst_i = 1;
        repeat (4) tick();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst_i          = ($urandom_range(0, 199) != 0);
            stallreq_id_i  = ($urandom_range(0, 3) == 0);
            stallreq_ex_i  = ($urandom_range(0, 3) == 0);
            stallreq_mem_i = ($urandom_range(0, 2) == 0);
            irq_ext_i      = ($urandom_range(0, 5) == 0);
`ifdef PIPE_IRQ_TIMER_EN
            irq_timer_i    = ($urandom_range(0, 5) == 0);
`endif
            mstatus_i      = $urandom;
            mie_i          = $urandom | (($urandom_range(0, 3) != 0) ? 32'h880 : 32'h0);
            mtvec_i        = $urandom;
            mepc_i         = $urandom;
            ex_pc_i        = $urandom & ~32'h3;
            ex_valid_i     = ($urandom_range(0, 4) != 0);
            mret_i         = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
